serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit.sv | 150 +++++++++++++++
 tb/tb_serial_logic_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// -----------------------------------------------------------------------------
// serial_logic_unit
//
// Purpose:
//   Bitwise logic unit (AND / OR / XOR / NOR) that processes a WIDTH-bit
//   operand pair CHUNK bits per clock cycle. The LSB chunk is processed first.
//   The operands and the opcode are captured when a request is accepted, so
//   the inputs may change freely while the operation runs. The result and the
//   zero flag are valid from the done pulse until the next accept.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits processed per cycle; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk     in   1      clock, rising edge active
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only while busy is low
//   op      in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   busy    out  1      operation in progress
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  registered result
//   zero    out  1      registered flag, result == 0
// -----------------------------------------------------------------------------
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    // A single-chunk configuration still needs a one-bit counter.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             zero_q;

    logic [WIDTH-1:0] result_d;
    logic             last_d;

    // One chunk of the selected logic operation. NOR is the inverted OR,
    // and no chunk depends on any other chunk.
    function automatic logic [CHUNK-1:0] chunk_op(
        input logic [1:0]       o,
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y
    );
        logic [CHUNK-1:0] r;
        case (o)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    // Next result: only the chunk addressed by the counter is replaced.
    // The loop compares against constant indices, so no variable part-select
    // is needed. That keeps the N == 1 configuration clean.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                result_d[i*CHUNK +: CHUNK] = chunk_op(op_q,
                                                      a_q[i*CHUNK +: CHUNK],
                                                      b_q[i*CHUNK +: CHUNK]);
            end
        end
    end

    assign last_d = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless the last chunk is written.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        cnt_q    <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        zero_q   <= 1'b0;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    if (last_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        zero_q  <= (result_d == '0);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
module tb_serial_logic_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero;
    logic [31:0] result;

    logic        start2;
    logic [1:0]  op2;
    logic [15:0] a2, b2;
    logic        busy2, done2, zero2;
    logic [15:0] result2;

    int n_chk  = 0;
    int n_fail = 0;

    serial_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    serial_logic_unit #(.WIDTH(16), .CHUNK(16)) dut1c (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .zero(zero2)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Whole-word reference: the serial unit must match a plain bitwise op.
    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Present a request and check the accept edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        chk_eq("acc_busy", busy, 1'b1);
        chk_eq("acc_done", done, 1'b0);
        chk_eq("acc_zero", zero, 1'b0);
        chk_eq("acc_result", result, 32'h0);
    endtask

    // Four edges after accept: inputs scrambled, optional ignored start pulses.
    task automatic finish_op(input logic [31:0] exp, input bit pulse);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; op = 2'($urandom);
            start = (pulse && k < 4) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (k < 4) begin
                chk_eq("run_busy", busy, 1'b1);
                chk_eq("run_done", done, 1'b0);
            end else begin
                chk_eq("done_pulse", done, 1'b1);
                chk_eq("done_busy", busy, 1'b0);
                chk_eq("done_result", result, exp);
                chk_eq("done_zero", zero, (exp == 32'h0));
            end
        end
    endtask

    task automatic hold_check(input logic [31:0] exp);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        chk_eq("hold_done", done, 1'b0);
        chk_eq("hold_busy", busy, 1'b0);
        chk_eq("hold_result", result, exp);
        chk_eq("hold_zero", zero, (exp == 32'h0));
    endtask

    task automatic run2(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        logic [15:0] exp;
        full = ref_op(o, {16'h0, x}, {16'h0, y});
        exp  = full[15:0];
        @(negedge clk);
        op2 = o; a2 = x; b2 = y; start2 = 1'b1;
        @(posedge clk); #1;
        chk_eq("n1_acc_busy", busy2, 1'b1);
        chk_eq("n1_acc_done", done2, 1'b0);
        @(negedge clk);
        start2 = 1'b0; a2 = 16'($urandom); b2 = 16'($urandom);
        @(posedge clk); #1;
        chk_eq("n1_done", done2, 1'b1);
        chk_eq("n1_busy", busy2, 1'b0);
        chk_eq("n1_result", result2, exp);
        chk_eq("n1_zero", zero2, (exp == 16'h0));
        @(posedge clk); #1;
        chk_eq("n1_done_drop", done2, 1'b0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0;
        #12;
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_done", done, 1'b0);
        chk_eq("rst_result", result, 32'h0);
        chk_eq("rst_zero", zero, 1'b0);
        chk_eq("rst_busy2", busy2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        start_op(2'b01, 32'hFFFFFFFF, 32'h40A00400);
        finish_op(32'hFFFFFFFF, 1'b0);
        hold_check(32'hFFFFFFFF);

        start_op(2'b01, 32'h22220225, 32'hC2420423);
        finish_op(32'hE2620627, 1'b0);
        start_op(2'b00, 32'h22220225, 32'hC2420423);
        finish_op(32'h02020021, 1'b0);
        hold_check(32'h02020021);

        start_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op(32'h00000000, 1'b0);
        start_op(2'b11, 32'h00000000, 32'h00000000);   // issued in the done cycle
        finish_op(32'hFFFFFFFF, 1'b0);
        hold_check(32'hFFFFFFFF);

        start_op(2'b00, 32'h12345678, 32'hF0F0F0F0);
        finish_op(32'h10305070, 1'b1);
        hold_check(32'h10305070);

        // Reset in the middle of a run.
        start_op(2'b01, 32'hFFFFFFFF, 32'h00000000);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_busy", busy, 1'b0);
        chk_eq("mid_rst_done", done, 1'b0);
        chk_eq("mid_rst_result", result, 32'h0);
        chk_eq("mid_rst_zero", zero, 1'b0);
        op = 2'b10; a = 32'hAAAA5555; b = 32'hFFFF0000; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("in_rst_busy", busy, 1'b0);
        chk_eq("in_rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_eq("rel_accept_busy", busy, 1'b1);
        chk_eq("rel_accept_result", result, 32'h0);
        finish_op(32'h55555555, 1'b0);
        hold_check(32'h55555555);

        // Single-chunk configuration.
        run2(2'b00, 16'hF0F0, 16'h0FF0);

        // Randomized operations against the whole-word model.
        for (int it = 0; it < 24; it++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (o == 2'b10) y = x;
                else if (o == 2'b00) y = ~x;
                else if (o == 2'b11) y = 32'hFFFFFFFF;
            end
            start_op(o, x, y);
            finish_op(ref_op(o, x, y), 1'($urandom));
            if ($urandom_range(0, 1) == 1) hold_check(ref_op(o, x, y));
        end

        for (int it = 0; it < 8; it++) begin
            run2(2'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
